// File: rtl/control_logic_param_pkg.sv
// control_logic_param_pkg: opcodes, src2 codes, FSM states, decoded control bundle and field helpers
package cl_pkg;
    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_ADDI = 4'h5;
    localparam logic [3:0] OP_SLL  = 4'h6;
    localparam logic [3:0] OP_SRL  = 4'h7;
    localparam logic [3:0] OP_MUL  = 4'h8;
    localparam logic [3:0] OP_JMP  = 4'h9;
    localparam logic [3:0] OP_BEQZ = 4'hA;
    localparam logic [3:0] OP_HALT = 4'hF;
    localparam logic [1:0] SRC2_REG   = 2'b00;
    localparam logic [1:0] SRC2_IMM   = 2'b01;
    localparam logic [1:0] SRC2_SHAMT = 2'b10;
    typedef enum logic [2:0] {S_FETCH, S_EXEC, S_FLUSH, S_MUL_WAIT, S_HALT} state_e;
    typedef struct packed {
        logic [1:0] src2;
        logic       reg_write;
        logic       rd_select;
        logic       alu_out_select;
        logic       is_mul;
        logic       is_jmp;
        logic       is_beqz;
        logic       is_halt;
        logic       illegal;
    } ctrl_t;
    function automatic int rd_lsb(int iw, int aw);
        return iw - 4 - aw;
    endfunction
    function automatic int rs1_lsb(int iw, int aw);
        return iw - 4 - 2 * aw;
    endfunction
    function automatic int rs2_lsb(int iw, int aw);
        return iw - 4 - 3 * aw;
    endfunction
endpackage

// File: rtl/control_logic_param_if.sv
// control_logic_param_if: imem fetch port plus decoded datapath controls
interface control_logic_param_if #(
    parameter int IW      = 16,
    parameter int PC_W    = 8,
    parameter int REG_AW  = 3,
    parameter int IMM_W   = 6,
    parameter int SHAMT_W = 3
);
    logic [PC_W-1:0]    instr_addr;
    logic [IW-1:0]      instr_in;
    logic               alu_zero_i;
    logic               pc_select;
    logic [PC_W-1:0]    jump_addr;
    logic [1:0]         src2_select;
    logic               alu_out_select;
    logic               reg_write;
    logic               rd_select;
    logic               mul_flag;
    logic [IMM_W-1:0]   imm_o;
    logic [SHAMT_W-1:0] shamt_o;
    logic [REG_AW-1:0]  rs1_o;
    logic [REG_AW-1:0]  rs2_o;
    logic [REG_AW-1:0]  rd_o;
    logic [3:0]         opcode_o;
    logic               halted_o;
    logic               illegal_o;
    modport master (
        output instr_addr, pc_select, jump_addr, src2_select, alu_out_select, reg_write,
               rd_select, mul_flag, imm_o, shamt_o, rs1_o, rs2_o, rd_o, opcode_o, halted_o, illegal_o,
        input  instr_in, alu_zero_i
    );
    modport slave (
        input  instr_addr, pc_select, jump_addr, src2_select, alu_out_select, reg_write,
               rd_select, mul_flag, imm_o, shamt_o, rs1_o, rs2_o, rd_o, opcode_o, halted_o, illegal_o,
        output instr_in, alu_zero_i
    );
endinterface

// File: rtl/control_logic_param_decoder.sv
// cl_decoder: pure combinational opcode to control-bundle decode
module cl_decoder
    import cl_pkg::*;
(
    input  logic [3:0] opcode,
    output ctrl_t      ctrl
);
    logic alu;
    always_comb begin
        alu = opcode >= OP_ADD && opcode <= OP_SRL;
        ctrl.src2 = opcode == OP_ADDI ? SRC2_IMM :
                    (opcode == OP_SLL || opcode == OP_SRL) ? SRC2_SHAMT : SRC2_REG;
        ctrl.reg_write      = alu || opcode == OP_MUL;
        ctrl.rd_select      = alu || opcode == OP_MUL;
        ctrl.alu_out_select = opcode == OP_MUL;
        ctrl.is_mul         = opcode == OP_MUL;
        ctrl.is_jmp         = opcode == OP_JMP;
        ctrl.is_beqz        = opcode == OP_BEQZ;
        ctrl.is_halt        = opcode == OP_HALT;
        ctrl.illegal        = opcode > OP_BEQZ && opcode < OP_HALT;
    end
endmodule

// File: rtl/control_logic_param.sv
// control_logic_param: PC, IR, fetch/exec FSM and multiplier wait counter around cl_decoder
module control_logic_param
    import cl_pkg::*;
#(
    parameter int IW      = 16,
    parameter int PC_W    = 8,
    parameter int REG_AW  = 3,
    parameter int IMM_W   = 6,
    parameter int SHAMT_W = 3,
    parameter int MUL_LAT = 3
) (
    input logic clk,
    input logic rst,
    control_logic_param_if.master bus
);
    localparam int CW      = $clog2(MUL_LAT + 1);
    localparam int RD_LSB  = rd_lsb(IW, REG_AW);
    localparam int RS1_LSB = rs1_lsb(IW, REG_AW);
    localparam int RS2_LSB = rs2_lsb(IW, REG_AW);
    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d, exec_pc_q, exec_pc_d;
    logic [IW-1:0]   ir_q, ir_d, instr;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PC_W-1:0] target;
    logic            exec, act, taken, mul_last;
    ctrl_t           dec;
    // while waiting on the multiplier, imem already shows the next instruction, so decode from IR
    assign instr = state_q == S_MUL_WAIT ? ir_q : bus.instr_in;
    cl_decoder u_dec (.opcode(instr[IW-1 -: 4]), .ctrl(dec));
    always_comb begin
        exec     = state_q == S_EXEC;
        act      = exec || state_q == S_MUL_WAIT;
        taken    = exec && (dec.is_jmp || (dec.is_beqz && bus.alu_zero_i));
        target   = dec.is_jmp ? instr[PC_W-1:0] : exec_pc_q + PC_W'($signed(instr[IMM_W-1:0]));
        mul_last = state_q == S_MUL_WAIT ? cnt_q == CW'(1) : MUL_LAT == 1;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            pc_q      <= '0;
            exec_pc_q <= '0;
            ir_q      <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            exec_pc_q <= exec_pc_d;
            ir_q      <= ir_d;
            cnt_q     <= cnt_d;
        end
    end
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q + PC_W'(1);
        exec_pc_d = pc_q;
        ir_d      = ir_q;
        cnt_d     = cnt_q;
        if (state_q == S_FETCH || state_q == S_FLUSH) begin
            state_d = S_EXEC;
        end else if (state_q == S_HALT) begin
            pc_d = pc_q;
        end else if (state_q == S_MUL_WAIT) begin
            cnt_d = cnt_q - CW'(1);
            pc_d  = mul_last ? pc_q + PC_W'(1) : pc_q;
            state_d = mul_last ? S_EXEC : S_MUL_WAIT;
        end else begin
            ir_d = bus.instr_in;
            if (taken) begin
                pc_d    = target;
                state_d = S_FLUSH;
            end else if (dec.is_halt) begin
                pc_d    = pc_q;
                state_d = S_HALT;
            end else if (dec.is_mul && MUL_LAT > 1) begin
                pc_d    = pc_q;
                cnt_d   = CW'(MUL_LAT - 1);
                state_d = S_MUL_WAIT;
            end
        end
    end
    always_comb begin
        bus.instr_addr     = pc_q;
        bus.pc_select      = taken;
        bus.jump_addr      = taken ? target : '0;
        bus.src2_select    = act ? dec.src2 : SRC2_REG;
        bus.reg_write      = act && dec.reg_write && (!dec.is_mul || mul_last);
        bus.alu_out_select = act && dec.alu_out_select && mul_last;
        bus.rd_select      = act && dec.rd_select;
        bus.mul_flag       = act && dec.is_mul;
        bus.imm_o          = act ? instr[IMM_W-1:0] : '0;
        bus.shamt_o        = act ? instr[SHAMT_W-1:0] : '0;
        bus.rd_o           = act ? instr[RD_LSB +: REG_AW] : '0;
        bus.rs1_o          = act ? instr[RS1_LSB +: REG_AW] : '0;
        bus.rs2_o          = act ? instr[RS2_LSB +: REG_AW] : '0;
        bus.opcode_o       = act ? instr[IW-1 -: 4] : '0;
        bus.halted_o       = state_q == S_HALT;
        bus.illegal_o      = exec && dec.illegal;
    end
endmodule

// File: tb/tb_control_logic_param.sv
// tb_control_logic_param: directed program through a sync-read imem model, table plus corner sequences
module tb_control_logic_param;
    typedef struct packed {
        logic       z;
        logic [7:0] addr;
        logic       ps;
        logic [7:0] ja;
        logic       rw;
        logic       aos;
        logic       mul;
        logic [1:0] src2;
        logic       rds;
        logic       ill;
        logic       hlt;
    } vec_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [15:0] mem [0:255];
    int checks = 0;
    int failures = 0;
    vec_t vec [0:19];
    control_logic_param_if bus ();
    control_logic_param dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) bus.instr_in <= mem[bus.instr_addr];
    function automatic vec_t observe(logic z);
        return '{z, bus.instr_addr, bus.pc_select, bus.jump_addr, bus.reg_write, bus.alu_out_select,
                 bus.mul_flag, bus.src2_select, bus.rd_select, bus.illegal_o, bus.halted_o};
    endfunction
    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask
    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    endtask
    task automatic do_reset();
        rst = 1'b1;
        bus.alu_zero_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask
    initial begin
        bus.alu_zero_i = 1'b0;
        clear_mem();
        mem[0] = 16'h1298; mem[1] = 16'h2298; mem[2] = 16'h5005; mem[3] = 16'h9040;
        mem[4] = 16'hB000; mem[5] = 16'hA03E; mem[6] = 16'h8298; mem[7] = 16'hC000;
        mem[8] = 16'h9005; mem[9] = 16'hD000;
        mem[8'h40] = 16'h6003; mem[8'h41] = 16'h9005; mem[8'h42] = 16'h1298;
        //          z  addr   ps ja     rw aos mul src2 rds ill hlt
        vec[0]  = '{0, 8'h00, 0, 8'h00, 0, 0, 0, 2'd0, 0, 0, 0};
        vec[1]  = '{0, 8'h01, 0, 8'h00, 1, 0, 0, 2'd0, 1, 0, 0};
        vec[2]  = '{0, 8'h02, 0, 8'h00, 1, 0, 0, 2'd0, 1, 0, 0};
        vec[3]  = '{0, 8'h03, 0, 8'h00, 1, 0, 0, 2'd1, 1, 0, 0};
        vec[4]  = '{0, 8'h04, 1, 8'h40, 0, 0, 0, 2'd0, 0, 0, 0};
        vec[5]  = '{0, 8'h40, 0, 8'h00, 0, 0, 0, 2'd0, 0, 0, 0};
        vec[6]  = '{1, 8'h41, 0, 8'h00, 1, 0, 0, 2'd2, 1, 0, 0};
        vec[7]  = '{0, 8'h42, 1, 8'h05, 0, 0, 0, 2'd0, 0, 0, 0};
        vec[8]  = '{0, 8'h05, 0, 8'h00, 0, 0, 0, 2'd0, 0, 0, 0};
        vec[9]  = '{0, 8'h06, 0, 8'h00, 0, 0, 0, 2'd0, 0, 0, 0};
        vec[10] = '{0, 8'h07, 0, 8'h00, 0, 0, 1, 2'd0, 1, 0, 0};
        vec[11] = '{0, 8'h07, 0, 8'h00, 0, 0, 1, 2'd0, 1, 0, 0};
        vec[12] = '{0, 8'h07, 0, 8'h00, 1, 1, 1, 2'd0, 1, 0, 0};
        vec[13] = '{0, 8'h08, 0, 8'h00, 0, 0, 0, 2'd0, 0, 1, 0};
        vec[14] = '{0, 8'h09, 1, 8'h05, 0, 0, 0, 2'd0, 0, 0, 0};
        vec[15] = '{0, 8'h05, 0, 8'h00, 0, 0, 0, 2'd0, 0, 0, 0};
        vec[16] = '{1, 8'h06, 1, 8'h03, 0, 0, 0, 2'd0, 0, 0, 0};
        vec[17] = '{1, 8'h03, 0, 8'h00, 0, 0, 0, 2'd0, 0, 0, 0};
        vec[18] = '{0, 8'h04, 1, 8'h40, 0, 0, 0, 2'd0, 0, 0, 0};
        vec[19] = '{0, 8'h40, 0, 8'h00, 0, 0, 0, 2'd0, 0, 0, 0};
        @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", 32'(observe(1'b0)), 32'(vec_t'(0)));
        do_reset();
        for (int i = 0; i < 20; i++) begin
            bus.alu_zero_i = vec[i].z;
            #1;
            chk($sformatf("vec%0d", i), 32'(observe(vec[i].z)), 32'(vec[i]));
            @(negedge clk);
        end
        // PC wrap past 0xFF
        clear_mem();
        mem[0] = 16'h90FE; mem[8'hFF] = 16'h1298;
        do_reset();
        repeat (3) @(negedge clk);
        #1 chk("wrap_addr_ff", 32'(bus.instr_addr), 32'h0000_00FF);
        @(negedge clk);
        #1 chk("wrap_addr_00", 32'(bus.instr_addr), 32'h0);
        chk("wrap_rw", 32'(bus.reg_write), 32'h1);
        // illegal opcode, then HALT
        clear_mem();
        mem[0] = 16'hC123; mem[1] = 16'hF000; mem[2] = 16'h1298;
        do_reset();
        @(negedge clk);
        #1 chk("illegal_pulse", 32'({bus.illegal_o, bus.reg_write, bus.instr_addr}), 32'({1'b1, 1'b0, 8'h01}));
        @(negedge clk);
        #1 chk("halt_exec", 32'({bus.illegal_o, bus.halted_o, bus.reg_write, bus.instr_addr}), 32'({3'b000, 8'h02}));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1 chk($sformatf("halted%0d", i), 32'({bus.halted_o, bus.reg_write, bus.instr_addr}), 32'({2'b10, 8'h02}));
        end
        // reset while waiting on the multiplier
        clear_mem();
        mem[0] = 16'h8298;
        do_reset();
        @(negedge clk);
        #1 chk("mul_exec", 32'({bus.mul_flag, bus.reg_write, bus.instr_addr}), 32'({2'b10, 8'h01}));
        @(negedge clk);
        #1 chk("mul_wait", 32'({bus.mul_flag, bus.reg_write, bus.instr_addr}), 32'({2'b10, 8'h01}));
        rst = 1'b1;
        @(negedge clk);
        #1 chk("mul_rst", 32'({bus.mul_flag, bus.reg_write, bus.alu_out_select, bus.instr_addr}), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        #1 chk("mul_rst_after", 32'({bus.mul_flag, bus.reg_write, bus.alu_out_select, bus.instr_addr}), 32'({3'b100, 8'h01}));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
